vga_mem_arb: RTL and testbench

- Arbitrates one shared frame-buffer memory port between two requesters:
  - the display refill requester, which reads bursts into the VGA line buffer (clk_65m domain);
  - the pixel writer/drawing engine, which writes bursts.
- Display refill has deadline priority via an urgency flag. Otherwise the two requesters alternate round-robin.
- Bursts are non-preemptive. Sits between the vga timing/line-buffer logic and the memory controller, all on one clock.

---
 rtl/vga_mem_pkg.sv | 28 ++
 rtl/vga_arb_pick.sv | 25 ++
 rtl/vga_mem_arb.sv | 199 +++++++++++++++++++
 tb/tb_vga_mem_arb.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_mem_pkg.sv
// Shared constants for the VGA frame-buffer arbiter: state encoding, requester IDs, default widths.
// Optional statistics outputs are enabled in vga_mem_arb by defining VGA_ARB_STATS_EN.
package vga_mem_pkg;

    localparam int unsigned ADDR_W_DEF    = 20;
    localparam int unsigned DATA_W_DEF    = 16;
    localparam int unsigned BURST_LEN_DEF = 16;
    localparam int unsigned LEN_W_DEF     = 5;
    localparam int unsigned STAT_W        = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_CMD  = 3'd1,
        RD_DATA = 3'd2,
        WR_CMD  = 3'd3,
        WR_DATA = 3'd4
    } arb_state_e;

    // Requester IDs as held in last_grant
    localparam logic RD = 1'b0;
    localparam logic WR = 1'b1;

    // Saturating increment for the statistics counters
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v, input logic en);
        return (en && (v != {STAT_W{1'b1}})) ? v + STAT_W'(1) : v;
    endfunction

endpackage

// File: rtl/vga_arb_pick.sv
// Two-way grant selector: display urgency first, then round-robin against last_grant.
module vga_arb_pick
    import vga_mem_pkg::*;
(
    input  logic       disp_req,
    input  logic       disp_urgent,
    input  logic       wr_req,
    input  logic       last_grant,
    output logic [1:0] gnt_c      // bit 0 = display read, bit 1 = writer
);

    always_comb begin
        gnt_c = 2'b00;
        if (disp_req && disp_urgent) begin
            gnt_c = 2'b01;
        end else if (disp_req && wr_req) begin
            gnt_c = (last_grant == RD) ? 2'b10 : 2'b01;
        end else if (disp_req) begin
            gnt_c = 2'b01;
        end else if (wr_req) begin
            gnt_c = 2'b10;
        end
    end

endmodule

// File: rtl/vga_mem_arb.sv
// Frame-buffer memory port arbiter between display refill reads and drawing-engine writes.
// Define VGA_ARB_STATS_EN to add saturating burst/urgency statistics outputs.
module vga_mem_arb
    import vga_mem_pkg::*;
#(
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned BURST_LEN = BURST_LEN_DEF,
    parameter int unsigned LEN_W     = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_req,
    input  logic              disp_urgent,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_gnt,
    output logic [DATA_W-1:0] disp_rdata,
    output logic              disp_rvalid,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [LEN_W-1:0]  wr_len,
    output logic              wr_gnt,
    input  logic [DATA_W-1:0] wr_wdata,
    input  logic              wr_wvalid,
    output logic              wr_wready,
    output logic              mem_cmd_valid,
    input  logic              mem_cmd_ready,
    output logic              mem_cmd_we,
    output logic [ADDR_W-1:0] mem_cmd_addr,
    output logic [LEN_W-1:0]  mem_cmd_len,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wvalid,
    input  logic              mem_wready,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid
`ifdef VGA_ARB_STATS_EN
    ,
    output logic [15:0]       stat_rd_bursts,
    output logic [15:0]       stat_wr_bursts,
    output logic [15:0]       stat_urgent_wait
`endif
);

    localparam logic [LEN_W-1:0] BURST_LEN_L = LEN_W'(BURST_LEN);

    arb_state_e        state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  beat_q, beat_d;
    logic [1:0]        pick_gnt;

    vga_arb_pick u_pick (
        .disp_req    (disp_req),
        .disp_urgent (disp_urgent),
        .wr_req      (wr_req),
        .last_grant  (last_grant_q),
        .gnt_c       (pick_gnt)
    );

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= WR;
            addr_q       <= '0;
            len_q        <= '0;
            beat_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            beat_q       <= beat_d;
        end
    end

    // Next state; command fields are captured on the IDLE decision and held until accepted
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        len_d        = len_q;
        beat_d       = beat_q;
        case (state_q)
            IDLE: begin
                if (pick_gnt[0]) begin
                    state_d = RD_CMD;
                    addr_d  = disp_addr;
                    len_d   = BURST_LEN_L;
                end else if (pick_gnt[1]) begin
                    state_d = WR_CMD;
                    addr_d  = wr_addr;
                    len_d   = (wr_len == '0) ? LEN_W'(1) : wr_len;
                end
            end
            RD_CMD: begin
                if (mem_cmd_ready) begin
                    state_d      = RD_DATA;
                    last_grant_d = RD;
                    beat_d       = '0;
                end
            end
            RD_DATA: begin
                if (mem_rvalid) begin
                    beat_d = beat_q + LEN_W'(1);
                    if (beat_q == BURST_LEN_L - LEN_W'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            WR_CMD: begin
                if (mem_cmd_ready) begin
                    state_d      = WR_DATA;
                    last_grant_d = WR;
                    beat_d       = '0;
                end
            end
            WR_DATA: begin
                if (wr_wvalid && mem_wready) begin
                    beat_d = beat_q + LEN_W'(1);
                    if (beat_q == len_q - LEN_W'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state; data handshakes pass straight through in their data state
    always_comb begin
        disp_gnt      = 1'b0;
        disp_rdata    = '0;
        disp_rvalid   = 1'b0;
        wr_gnt        = 1'b0;
        wr_wready     = 1'b0;
        mem_cmd_valid = 1'b0;
        mem_cmd_we    = 1'b0;
        mem_cmd_addr  = '0;
        mem_cmd_len   = '0;
        mem_wdata     = '0;
        mem_wvalid    = 1'b0;
        case (state_q)
            RD_CMD: begin
                mem_cmd_valid = 1'b1;
                mem_cmd_addr  = addr_q;
                mem_cmd_len   = len_q;
                disp_gnt      = mem_cmd_ready;
            end
            RD_DATA: begin
                disp_rvalid = mem_rvalid;
                disp_rdata  = mem_rdata;
            end
            WR_CMD: begin
                mem_cmd_valid = 1'b1;
                mem_cmd_we    = 1'b1;
                mem_cmd_addr  = addr_q;
                mem_cmd_len   = len_q;
                wr_gnt        = mem_cmd_ready;
            end
            WR_DATA: begin
                mem_wvalid = wr_wvalid;
                mem_wdata  = wr_wdata;
                wr_wready  = mem_wready;
            end
            default: ;
        endcase
    end

`ifdef VGA_ARB_STATS_EN
    logic [STAT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [STAT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [STAT_W-1:0] uw_cnt_q, uw_cnt_d;

    always_comb begin
        rd_cnt_d = sat_inc(rd_cnt_q, disp_gnt);
        wr_cnt_d = sat_inc(wr_cnt_q, wr_gnt);
        uw_cnt_d = sat_inc(uw_cnt_q, disp_urgent && (state_q != RD_CMD) && (state_q != RD_DATA));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            uw_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
            uw_cnt_q <= uw_cnt_d;
        end
    end

    assign stat_rd_bursts   = rd_cnt_q;
    assign stat_wr_bursts   = wr_cnt_q;
    assign stat_urgent_wait = uw_cnt_q;
`endif

endmodule

// File: tb/tb_vga_mem_arb.sv
// Randomized transaction-level bench for vga_mem_arb with a behavioural arbitration/transfer model.
module tb_vga_mem_arb;

    logic        clk;
    logic        rst;
    logic        disp_req, disp_urgent;
    logic [19:0] disp_addr;
    logic        disp_gnt;
    logic [15:0] disp_rdata;
    logic        disp_rvalid;
    logic        wr_req;
    logic [19:0] wr_addr;
    logic [4:0]  wr_len;
    logic        wr_gnt;
    logic [15:0] wr_wdata;
    logic        wr_wvalid, wr_wready;
    logic        mem_cmd_valid, mem_cmd_ready, mem_cmd_we;
    logic [19:0] mem_cmd_addr;
    logic [4:0]  mem_cmd_len;
    logic [15:0] mem_wdata;
    logic        mem_wvalid, mem_wready;
    logic [15:0] mem_rdata;
    logic        mem_rvalid;
`ifdef VGA_ARB_STATS_EN
    logic [15:0] stat_rd_bursts, stat_wr_bursts, stat_urgent_wait;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Model state: who was granted last, burst counts, and whether a display burst owns the port
    logic model_last;
    int   exp_rd_n, exp_wr_n, exp_uw;
    logic rd_phase;

    vga_mem_arb dut (
        .clk           (clk),
        .rst           (rst),
        .disp_req      (disp_req),
        .disp_urgent   (disp_urgent),
        .disp_addr     (disp_addr),
        .disp_gnt      (disp_gnt),
        .disp_rdata    (disp_rdata),
        .disp_rvalid   (disp_rvalid),
        .wr_req        (wr_req),
        .wr_addr       (wr_addr),
        .wr_len        (wr_len),
        .wr_gnt        (wr_gnt),
        .wr_wdata      (wr_wdata),
        .wr_wvalid     (wr_wvalid),
        .wr_wready     (wr_wready),
        .mem_cmd_valid (mem_cmd_valid),
        .mem_cmd_ready (mem_cmd_ready),
        .mem_cmd_we    (mem_cmd_we),
        .mem_cmd_addr  (mem_cmd_addr),
        .mem_cmd_len   (mem_cmd_len),
        .mem_wdata     (mem_wdata),
        .mem_wvalid    (mem_wvalid),
        .mem_wready    (mem_wready),
        .mem_rdata     (mem_rdata),
        .mem_rvalid    (mem_rvalid)
`ifdef VGA_ARB_STATS_EN
        ,
        .stat_rd_bursts   (stat_rd_bursts),
        .stat_wr_bursts   (stat_wr_bursts),
        .stat_urgent_wait (stat_urgent_wait)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Urgency-wait reference: every cycle urgent is high while no display burst owns the port
    always @(posedge clk) begin
        if (rst) exp_uw <= 0;
        else if (disp_urgent && !rd_phase && exp_uw != 65535) exp_uw <= exp_uw + 1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cmd_valid"}, 32'(mem_cmd_valid), 0);
        check({tag, "_cmd_we"},    32'(mem_cmd_we), 0);
        check({tag, "_cmd_addr"},  32'(mem_cmd_addr), 0);
        check({tag, "_cmd_len"},   32'(mem_cmd_len), 0);
        check({tag, "_disp_gnt"},  32'(disp_gnt), 0);
        check({tag, "_wr_gnt"},    32'(wr_gnt), 0);
        check({tag, "_rvalid"},    32'(disp_rvalid), 0);
        check({tag, "_rdata"},     32'(disp_rdata), 0);
        check({tag, "_wready"},    32'(wr_wready), 0);
        check({tag, "_mwvalid"},   32'(mem_wvalid), 0);
        check({tag, "_mwdata"},    32'(mem_wdata), 0);
    endtask

    task automatic check_stats(input string tag);
`ifdef VGA_ARB_STATS_EN
        check({tag, "_stat_rd"}, 32'(stat_rd_bursts), 32'(exp_rd_n));
        check({tag, "_stat_wr"}, 32'(stat_wr_bursts), 32'(exp_wr_n));
        check({tag, "_stat_uw"}, 32'(stat_urgent_wait), 32'(exp_uw));
`else
        check({tag, "_idle_valid"}, 32'(mem_cmd_valid), 0);
`endif
    endtask

    task automatic drive_quiet();
        disp_req = 0; disp_urgent = 0; wr_req = 0;
        disp_addr = '0; wr_addr = '0; wr_len = '0; wr_wdata = '0; wr_wvalid = 0;
        mem_cmd_ready = 0; mem_wready = 0; mem_rdata = '0; mem_rvalid = 0;
    endtask

    // Leaves the DUT idle just after a clock edge
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive_quiet();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #1;
        check_all_zero("reset");
        model_last = 1'b1;
        exp_rd_n = 0; exp_wr_n = 0;
        rd_phase = 1'b0;
        check_stats("reset");
        rst = 1'b0;
        @(posedge clk);
    endtask

    // One arbitration decision plus the whole granted burst. stall<0: random memory
    // handshakes; stall>=0: command ready after 'stall' cycles and fixed data patterns.
    task automatic do_txn(input logic dq, input logic ur, input logic wq,
                          input logic [19:0] da, input logic [19:0] wa,
                          input logic [4:0] wl, input int stall);
        logic        exp_rd, acc, beat;
        logic [4:0]  elen;
        logic [19:0] eaddr;
        int          beats, n, guard;
        @(negedge clk);
        rd_phase = 1'b0;
        disp_req = dq; disp_urgent = ur; wr_req = wq;
        disp_addr = da; wr_addr = wa; wr_len = wl;
        mem_cmd_ready = 0;
        mem_rvalid = 1; mem_rdata = 16'($urandom);
        wr_wvalid = 1; mem_wready = 1; wr_wdata = 16'($urandom);
        #1;
        check("idle_cmd_valid", 32'(mem_cmd_valid), 0);
        check("idle_rvalid_ignored", 32'(disp_rvalid), 0);
        check("idle_wready", 32'(wr_wready), 0);
        check("idle_mwvalid", 32'(mem_wvalid), 0);
        if (!dq && !wq) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            check("noreq_cmd_valid", 32'(mem_cmd_valid), 0);
            @(posedge clk);
            return;
        end
        if (dq && ur)      exp_rd = 1'b1;
        else if (dq && wq) exp_rd = (model_last == 1'b1);
        else               exp_rd = dq;
        elen  = exp_rd ? 5'd16 : ((wl == 5'd0) ? 5'd1 : wl);
        eaddr = exp_rd ? da : wa;
        @(posedge clk);

        acc = 1'b0;
        guard = 0;
        while (!acc && guard < 40) begin
            @(negedge clk);
            rd_phase = exp_rd;
            mem_rvalid = 1'($urandom_range(0, 1));
            mem_cmd_ready = (stall < 0) ? ($urandom_range(0, 2) != 0) : (guard >= stall);
            if (guard > 0) begin
                if (stall >= 0 || $urandom_range(0, 1) == 1) begin
                    disp_req = 0; wr_req = 0;
                end
                disp_addr = 20'($urandom); wr_addr = 20'($urandom); wr_len = 5'($urandom);
            end
            #1;
            check("cmd_valid", 32'(mem_cmd_valid), 1);
            check("cmd_we", 32'(mem_cmd_we), 32'(!exp_rd));
            check("cmd_addr", 32'(mem_cmd_addr), 32'(eaddr));
            check("cmd_len", 32'(mem_cmd_len), 32'(elen));
            check("disp_gnt", 32'(disp_gnt), 32'(mem_cmd_ready && exp_rd));
            check("wr_gnt", 32'(wr_gnt), 32'(mem_cmd_ready && !exp_rd));
            check("cmd_rvalid_ignored", 32'(disp_rvalid), 0);
            acc = mem_cmd_ready;
            guard++;
            @(posedge clk);
        end
        if (!acc) begin
            check("cmd_accept_timeout", 0, 1);
            return;
        end
        model_last = exp_rd ? 1'b0 : 1'b1;
        if (exp_rd) exp_rd_n++; else exp_wr_n++;

        n = int'(elen);
        beats = 0;
        guard = 0;
        while (beats < n && guard < 200) begin
            @(negedge clk);
            mem_cmd_ready = 1'($urandom_range(0, 1));
            mem_rdata = 16'($urandom);
            wr_wdata = 16'($urandom);
            if (stall >= 0) begin
                mem_rvalid = 1;
                wr_wvalid = 1;
                mem_wready = (guard % 2 == 0);
            end else begin
                mem_rvalid = ($urandom_range(0, 3) != 0);
                wr_wvalid = ($urandom_range(0, 3) != 0);
                mem_wready = ($urandom_range(0, 3) != 0);
            end
            #1;
            check("data_cmd_valid", 32'(mem_cmd_valid), 0);
            if (exp_rd) begin
                beat = mem_rvalid;
                check("rd_rvalid", 32'(disp_rvalid), 32'(mem_rvalid));
                if (mem_rvalid) check("rd_rdata", 32'(disp_rdata), 32'(mem_rdata));
                check("rd_wready_low", 32'(wr_wready), 0);
                check("rd_mwvalid_low", 32'(mem_wvalid), 0);
            end else begin
                beat = wr_wvalid && mem_wready;
                check("wr_mwvalid", 32'(mem_wvalid), 32'(wr_wvalid));
                check("wr_wready", 32'(wr_wready), 32'(mem_wready));
                check("wr_mwdata", 32'(mem_wdata), 32'(wr_wdata));
                check("wr_rvalid_ignored", 32'(disp_rvalid), 0);
            end
            if (beat) beats++;
            guard++;
            @(posedge clk);
        end
        if (beats < n) check("data_timeout", 32'(beats), 32'(n));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        rd_phase = 1'b0;
        model_last = 1'b1;
        exp_rd_n = 0; exp_wr_n = 0;
        drive_quiet();
        do_reset();

        // Single display read at 0x00100 with ready tied high
        do_txn(1, 0, 0, 20'h00100, 20'h0, 5'd0, 0);

        // Continuous contention: alternation starting with display after reset
        do_reset();
        for (int i = 0; i < 4; i++)
            do_txn(1, 0, 1, 20'($urandom), 20'($urandom), 5'($urandom_range(1, 16)), -1);

        // Display just won, urgency must let it win again
        do_txn(1, 0, 1, 20'($urandom), 20'($urandom), 5'd4, -1);
        do_txn(1, 1, 1, 20'($urandom), 20'($urandom), 5'd4, -1);

        // Three-beat write against toggling wready; then a 5-cycle command stall with request drop
        do_txn(0, 0, 1, 20'h0, 20'h0ABCD, 5'd3, 0);
        do_txn(0, 1, 1, 20'h0, 20'hF0F0F, 5'd7, 5);
        // Zero length clamps to one beat; an idle cycle with no requests
        do_txn(0, 0, 1, 20'h0, 20'h12345, 5'd0, -1);
        do_txn(0, 1, 0, 20'h0, 20'h0, 5'd0, -1);

        for (int i = 0; i < 40; i++)
            do_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   20'($urandom), 20'($urandom), 5'($urandom_range(0, 16)), -1);
        check_stats("mid");

        // Reset during beat 8 of a display burst
        @(negedge clk);
        disp_req = 1; wr_req = 0; disp_urgent = 0; disp_addr = 20'h00200;
        mem_cmd_ready = 1; mem_rvalid = 0;
        @(posedge clk);
        @(negedge clk);
        rd_phase = 1'b1;
        disp_req = 0;
        @(posedge clk);
        exp_rd_n++;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            mem_rvalid = 1; mem_rdata = 16'($urandom);
            @(posedge clk);
        end
        @(negedge clk);
        rst = 1'b1;
        mem_rvalid = 1;
        @(posedge clk);
        @(negedge clk);
        #1;
        check_all_zero("midburst_rst");
        exp_rd_n = 0; exp_wr_n = 0;
        model_last = 1'b1;
        rd_phase = 1'b0;
        check_stats("midburst_rst");
        rst = 1'b0;
        mem_rvalid = 0; mem_cmd_ready = 0;
        @(posedge clk);

        // After reset display wins the first tie again
        do_txn(1, 0, 1, 20'h00300, 20'h00400, 5'd2, -1);
        do_txn(1, 0, 1, 20'h00500, 20'h00600, 5'd2, -1);
        @(negedge clk);
        drive_quiet();
        rd_phase = 1'b0;
        #1;
        check_stats("final");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
